// File: rtl/qspi_ram_responder_if.sv
// QSPI pin bundle between an initiator (master) and the RAM responder (slave).
// spi_select is active low; spi_data_oe is a per-bit output enable driven by the responder.
interface qspi_ram_responder_if;
  logic       spi_select;
  logic       spi_clk;
  logic [3:0] spi_data_in;
  logic [3:0] spi_data_out;
  logic [3:0] spi_data_oe;

  modport master (
    output spi_select, spi_clk, spi_data_in,
    input  spi_data_out, spi_data_oe
  );

  modport slave (
    input  spi_select, spi_clk, spi_data_in,
    output spi_data_out, spi_data_oe
  );
endinterface

// File: rtl/qspi_ram_responder.sv
// QSPI 4-4-4 RAM responder (0x38 write / 0xEB read) on block RAM; QSPI_RAM_CMD_ERR_EN adds sticky cmd_err.
// Output nibble changes 1 clk after SCK fall is seen; no backpressure, fully paced by the initiator's SCK.
module qspi_ram_responder #(
  parameter int ADDR_BITS    = 12,
  parameter int DUMMY_CYCLES = 6
) (
  input  logic               clk,
  input  logic               rst,
  qspi_ram_responder_if.slave bus
`ifdef QSPI_RAM_CMD_ERR_EN
  ,
  output logic               cmd_err
`endif
);

  localparam int CW = ($clog2(DUMMY_CYCLES) > 3) ? $clog2(DUMMY_CYCLES) : 3;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WR_DATA, DUMMY, RD_DATA, IGNORE} state_t;

  state_t                 state_q, state_d;
  logic                   sck_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [3:0]             cmd_hi_q, cmd_hi_d;
  logic                   is_wr_q, is_wr_d;
  logic [ADDR_BITS-1:0]   ptr_q, ptr_d;
  logic                   phase_q, phase_d;
  logic [3:0]             half_q, half_d;
  logic [3:0]             out_q, out_d;
  logic                   oe_q, oe_d;

  logic [7:0]             mem [0:(1<<ADDR_BITS)-1];
  logic [7:0]             rd_q;
  logic                   rd_en, we;
  logic [ADDR_BITS-1:0]   rd_addr;

  logic                   sel, rise, fall;
  logic [3:0]             din;
  logic [7:0]             cmd_byte;
  logic                   cmd_ok, cmd_done, addr_done, dummy_done;

  assign sel        = ~bus.spi_select;
  assign din        = bus.spi_data_in;
  assign rise       = bus.spi_clk & ~sck_q;
  assign fall       = ~bus.spi_clk & sck_q;
  assign cmd_byte   = {cmd_hi_q, din};
  assign cmd_ok     = (cmd_byte == 8'h38) || (cmd_byte == 8'hEB);
  assign cmd_done   = sel && (state_q == CMD) && rise && (cnt_q == CW'(1));
  assign addr_done  = sel && (state_q == ADDR) && rise && (cnt_q == CW'(5));
  assign dummy_done = sel && (state_q == DUMMY) && fall && (cnt_q == CW'(DUMMY_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!sel) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = CMD;
        CMD:     if (cmd_done) state_d = cmd_ok ? ADDR : IGNORE;
        ADDR:    if (addr_done) state_d = is_wr_q ? WR_DATA : DUMMY;
        DUMMY:   if (dummy_done) state_d = RD_DATA;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    cmd_hi_d = cmd_hi_q;
    is_wr_d  = is_wr_q;
    ptr_d    = ptr_q;
    phase_d  = phase_q;
    half_d   = half_q;
    out_d    = out_q;
    oe_d     = oe_q;
    rd_en    = 1'b0;
    rd_addr  = ptr_q;
    we       = 1'b0;
    if (!sel) begin
      cnt_d   = '0;
      phase_d = 1'b0;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        CMD: if (rise) begin
          cmd_hi_d = din;
          cnt_d    = cmd_done ? '0 : cnt_q + CW'(1);
          if (cmd_done) is_wr_d = (cmd_byte == 8'h38);
        end
        ADDR: if (rise) begin
          // Only the low ADDR_BITS survive the shift, so upper address bits fall away.
          ptr_d = {ptr_q[ADDR_BITS-5:0], din};
          cnt_d = addr_done ? '0 : cnt_q + CW'(1);
          if (addr_done) begin
            rd_en   = 1'b1;
            rd_addr = ptr_d;
          end
        end
        DUMMY: if (fall) begin
          cnt_d = dummy_done ? '0 : cnt_q + CW'(1);
          if (dummy_done) begin
            oe_d    = 1'b1;
            out_d   = rd_q[7:4];
            phase_d = 1'b1;
          end
        end
        RD_DATA: if (fall) begin
          if (phase_q) begin
            // Low nibble goes out now; fetch the next byte while it is on the wire.
            out_d   = rd_q[3:0];
            ptr_d   = ptr_q + ADDR_BITS'(1);
            rd_en   = 1'b1;
            rd_addr = ptr_d;
            phase_d = 1'b0;
          end else begin
            out_d   = rd_q[7:4];
            phase_d = 1'b1;
          end
        end
        WR_DATA: if (rise) begin
          if (!phase_q) begin
            half_d  = din;
            phase_d = 1'b1;
          end else begin
            we      = 1'b1;
            ptr_d   = ptr_q + ADDR_BITS'(1);
            phase_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q    <= 1'b0;
      cnt_q    <= '0;
      cmd_hi_q <= '0;
      is_wr_q  <= 1'b0;
      ptr_q    <= '0;
      phase_q  <= 1'b0;
      half_q   <= '0;
      out_q    <= '0;
      oe_q     <= 1'b0;
    end else begin
      sck_q    <= bus.spi_clk;
      cnt_q    <= cnt_d;
      cmd_hi_q <= cmd_hi_d;
      is_wr_q  <= is_wr_d;
      ptr_q    <= ptr_d;
      phase_q  <= phase_d;
      half_q   <= half_d;
      out_q    <= out_d;
      oe_q     <= oe_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we && !rst) mem[ptr_q] <= {half_q, din};
    if (rd_en)      rd_q <= mem[rd_addr];
  end

  assign bus.spi_data_out = out_q;
  assign bus.spi_data_oe  = {4{oe_q}};

`ifdef QSPI_RAM_CMD_ERR_EN
  logic cmd_err_q;
  always_ff @(posedge clk) begin
    if (rst)                      cmd_err_q <= 1'b0;
    else if (cmd_done && !cmd_ok) cmd_err_q <= 1'b1;
  end
  assign cmd_err = cmd_err_q;
`endif

endmodule

// File: tb/tb_qspi_ram_responder.sv
// Random and directed QSPI transactions against a byte-array model; a monitor scores read nibbles at each SCK rise.
`timescale 1ns/1ps
module tb_qspi_ram_responder;
  localparam int AB   = 12;
  localparam int DC   = 6;
  localparam int HALF = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  qspi_ram_responder_if bus();
`ifdef QSPI_RAM_CMD_ERR_EN
  logic cmd_err;
`endif

  qspi_ram_responder #(.ADDR_BITS(AB), .DUMMY_CYCLES(DC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef QSPI_RAM_CMD_ERR_EN
    ,
    .cmd_err (cmd_err)
`endif
  );

  typedef struct packed {bit chk; logic [3:0] nib;} exp_t;

  int          n_cmp = 0;
  int          n_err = 0;
  exp_t        exp_q[$];
  bit   [7:0]  mem_m [0:(1<<AB)-1];
  bit          known_m [0:(1<<AB)-1];
  logic [7:0]  wbuf[$];
  logic [23:0] wa[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rise(input logic [3:0] nib);
    bus.spi_data_in = nib;
    bus.spi_clk     = 1'b1;
    tick(HALF);
  endtask

  task automatic fall();
    bus.spi_clk = 1'b0;
    tick(HALF);
  endtask

  task automatic nib_cycle(input logic [3:0] nib);
    rise(nib);
    fall();
  endtask

  task automatic deselect();
    bus.spi_select = 1'b1;
    bus.spi_clk    = 1'b0;
    tick(4);
  endtask

  // Command and address; the last address nibble is left with SCK high.
  task automatic hdr(input logic [7:0] cmd, input logic [23:0] a);
    bus.spi_select = 1'b0;
    tick(2);
    nib_cycle(cmd[7:4]);
    nib_cycle(cmd[3:0]);
    for (int i = 5; i > 0; i--) nib_cycle(a[i*4 +: 4]);
    rise(a[3:0]);
  endtask

  task automatic wr(input logic [23:0] a, input bit half, input logic [3:0] hn);
    logic [AB-1:0] p;
    hdr(8'h38, a);
    fall();
    p = a[AB-1:0];
    foreach (wbuf[i]) begin
      nib_cycle(wbuf[i][7:4]);
      nib_cycle(wbuf[i][3:0]);
      mem_m[p]   = wbuf[i];
      known_m[p] = 1'b1;
      p++;
    end
    if (half) nib_cycle(hn);
    deselect();
    wa.push_back(a);
  endtask

  task automatic rd(input logic [23:0] a, input int n, input int abort_at);
    logic [AB-1:0] p;
    exp_t e;
    int idx;
    hdr(8'hEB, a);
    for (int k = 1; k <= DC; k++) begin
      fall();
      check("oe_dummy", bus.spi_data_oe, (k == DC) ? 4'hF : 4'h0);
      if (k < DC) rise(4'($urandom));
    end
    p   = a[AB-1:0];
    idx = 0;
    for (int i = 0; i < n; i++) begin
      for (int h = 0; h < 2; h++) begin
        if (idx == abort_at) begin
          rst = 1'b1;
          tick(1);
          check("rst_oe", bus.spi_data_oe, 4'h0);
          check("rst_out", bus.spi_data_out, 4'h0);
          rst = 1'b0;
          exp_q.delete();
          deselect();
          return;
        end
        e.chk = known_m[p];
        e.nib = (h == 0) ? mem_m[p][7:4] : mem_m[p][3:0];
        exp_q.push_back(e);
        nib_cycle(4'($urandom));
        idx++;
      end
      p++;
    end
    deselect();
  endtask

  // Monitor: the initiator samples read data on each SCK rise.
  logic sck_prev = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (bus.spi_clk && !sck_prev) begin
      if (bus.spi_data_oe != 4'h0) begin
        check("oe_val", bus.spi_data_oe, 4'hF);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL oe_unexpected: oe=%0h with no read data due at %0t", bus.spi_data_oe, $time);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.chk) check("rd_nib", bus.spi_data_out, mon_e.nib);
        end
      end else if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("oe_missing", bus.spi_data_oe, 4'hF);
      end
    end
    sck_prev <= bus.spi_clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [23:0] a;
    int          n;
    rst             = 1'b1;
    bus.spi_select  = 1'b1;
    bus.spi_clk     = 1'b0;
    bus.spi_data_in = 4'h0;
    tick(3);
    check("reset_oe", bus.spi_data_oe, 4'h0);
    check("reset_out", bus.spi_data_out, 4'h0);
`ifdef QSPI_RAM_CMD_ERR_EN
    check("reset_cmd_err", cmd_err, 1'b0);
`endif
    rst = 1'b0;
    tick(2);

    wbuf = {8'hA5, 8'h3C};
    wr(24'h000010, 1'b0, 4'h0);
    rd(24'h000010, 2, -1);

    wbuf = {8'h11, 8'h22};
    wr(24'h000FFF, 1'b0, 4'h0);
    rd(24'h000FFF, 2, -1);
    rd(24'h5A3000, 1, -1);

    wbuf = {8'h66};
    wr(24'h000020, 1'b0, 4'h0);
    wbuf = {};
    wr(24'h000020, 1'b1, 4'h7);
    rd(24'h000020, 1, -1);

    hdr(8'h9F, 24'h000010);
    fall();
    for (int i = 0; i < 6; i++) begin
      nib_cycle(4'($urandom));
      check("oe_ignore", bus.spi_data_oe, 4'h0);
    end
    deselect();
`ifdef QSPI_RAM_CMD_ERR_EN
    check("cmd_err_set", cmd_err, 1'b1);
`endif
    rd(24'h000010, 2, -1);

    rd(24'h000010, 3, 3);
    rd(24'h000010, 1, -1);

    for (int t = 0; t < 30; t++) begin
      n = $urandom_range(1, 4);
      if (($urandom % 2) == 0 || wa.size() == 0) begin
        a = 24'($urandom);
        if (($urandom % 4) == 0) a[11:0] = 12'hFFE;
        wbuf = {};
        for (int i = 0; i < n; i++) wbuf.push_back(8'($urandom));
        wr(a, 1'($urandom % 3 == 0), 4'($urandom));
      end else begin
        a        = wa[$urandom_range(0, wa.size() - 1)];
        a[23:12] = 12'($urandom);
        rd(a, n, -1);
      end
    end

    tick(4);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
